// File: rtl/hsv_out_ctrl.sv
// Output FIFO controller for the H/S/V pixel datapath: buffers tri_done results and hands them downstream.
// Optional statistics counters (pix_cnt, drop_cnt) are built when HSV_OUT_STATS_EN is defined.
module hsv_out_ctrl #(
    parameter int H_W   = 9,
    parameter int SV_W  = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     tri_done,
    input  logic [H_W-1:0]           H_in,
    input  logic [SV_W-1:0]          S_in,
    input  logic [SV_W-1:0]          V_in,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [H_W-1:0]           H_out,
    output logic [SV_W-1:0]          S_out,
    output logic [SV_W-1:0]          V_out,
    output logic                     stall,
    output logic                     overflow,
`ifdef HSV_OUT_STATS_EN
    output logic [15:0]              pix_cnt,
    output logic [7:0]               drop_cnt,
`endif
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = H_W + 2 * SV_W;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(DEPTH - 1);

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic [ENTRY_W-1:0] mem_q [DEPTH];

    logic               empty;
    logic               full;
    logic               push;
    logic               pop;
    logic               drop;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] head_data;

    // Handshake: a head entry transfers on any rising edge where out_valid && out_ready;
    // out_valid never depends on out_ready, and the head holds while out_valid && !out_ready.
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == FULL_CNT);
        pop      = !empty && out_ready;
        push     = tri_done && (!full || pop);
        drop     = tri_done && !push;
        wr_entry = {H_in, S_in, V_in};
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | drop;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not reset; outputs are gated by empty instead, so stale entries never leak.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    always_comb begin
        head_data = empty ? '0 : mem_q[rd_ptr_q];
        out_valid = !empty;
        {H_out, S_out, V_out} = head_data;
        stall     = (count_q >= STALL_CNT);
        overflow  = overflow_q;
        level     = count_q;
    end

`ifdef HSV_OUT_STATS_EN
    logic [15:0] pix_cnt_q, pix_cnt_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;

    always_comb begin
        pix_cnt_d  = pix_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (pop) begin
            pix_cnt_d = pix_cnt_q + 16'd1;
        end
        // Drop counter saturates so a long overflow burst still reads as "many".
        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            pix_cnt_q  <= pix_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign pix_cnt  = pix_cnt_q;
    assign drop_cnt = drop_cnt_q;
`else
    // Statistics counters are not built in this configuration.
`endif

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        count_q <= FULL_CNT);

    a_head_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> $stable(head_data));

    a_overflow_sticky: assert property (@(posedge clk) disable iff (!rst_n)
        overflow_q |=> overflow_q);

endmodule
